// File: rtl/uart_line_ctrl_if.sv
// uart_line_ctrl_if: receive, line handshake and buffer read signals of the line controller.
// The echo_valid/echo_byte pair exists only when UART_LINE_CTRL_ECHO_EN is defined.
interface uart_line_ctrl_if #(parameter int MAX_LEN = 32);
    localparam int AW = $clog2(MAX_LEN);
    logic byte_ready;
    logic [7:0] data_in;
    logic line_valid;
    logic line_ready;
    logic [AW:0] line_len;
    logic [AW-1:0] rd_addr;
    logic [7:0] rd_data;
    logic overflow;
    logic rx_drop;
`ifdef UART_LINE_CTRL_ECHO_EN
    logic echo_valid;
    logic [7:0] echo_byte;
    modport slave (input byte_ready, data_in, line_ready, rd_addr,
                   output line_valid, line_len, rd_data, overflow, rx_drop, echo_valid, echo_byte);
    modport master (output byte_ready, data_in, line_ready, rd_addr,
                    input line_valid, line_len, rd_data, overflow, rx_drop, echo_valid, echo_byte);
`else
    modport slave (input byte_ready, data_in, line_ready, rd_addr,
                   output line_valid, line_len, rd_data, overflow, rx_drop);
    modport master (output byte_ready, data_in, line_ready, rd_addr,
                    input line_valid, line_len, rd_data, overflow, rx_drop);
`endif
endinterface

// File: rtl/uart_line_ctrl.sv
// uart_line_ctrl: assembles UART bytes into an editable line buffer and hands completed lines to a consumer.
// Define UART_LINE_CTRL_ECHO_EN to echo stored bytes and effective backspaces.
module uart_line_ctrl #(parameter int MAX_LEN = 32) (
    input logic clk,
    input logic rst_n,
    uart_line_ctrl_if.slave bus
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(MAX_LEN);
    typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} stateE;
    stateE state;
    logic [7:0] buffer [MAX_LEN];
    logic [LW-1:0] len;
    logic readyQ, accept, isPrint, isBs, isEol;
    always_comb begin
        accept = bus.byte_ready && !readyQ;
        isPrint = bus.data_in >= 8'h20 && bus.data_in <= 8'h7E;
        isBs = bus.data_in == 8'h08 || bus.data_in == 8'h7F;
        isEol = bus.data_in == 8'h0D || bus.data_in == 8'h0A;
    end
    assign bus.line_len = len;
    assign bus.rd_data = buffer[bus.rd_addr];
    // Buffer is never reset; stale bytes past line_len are harmless.
    always_ff @(posedge clk)
        if (state == COLLECT && accept && isPrint && len != FULL) buffer[len[AW-1:0]] <= bus.data_in;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
            len <= '0;
            readyQ <= 1'b1;
            bus.line_valid <= 1'b0;
            bus.overflow <= 1'b0;
            bus.rx_drop <= 1'b0;
`ifdef UART_LINE_CTRL_ECHO_EN
            bus.echo_valid <= 1'b0;
            bus.echo_byte <= '0;
`endif
        end else begin
            readyQ <= bus.byte_ready;
            bus.overflow <= 1'b0;
            bus.rx_drop <= 1'b0;
`ifdef UART_LINE_CTRL_ECHO_EN
            bus.echo_valid <= 1'b0;
`endif
            case (state)
                COLLECT: if (accept) begin
                    if (isPrint && len == FULL) begin
                        bus.overflow <= 1'b1;
                        len <= '0;
                        state <= DISCARD;
                    end else if (isPrint) begin
                        len <= len + 1'b1;
`ifdef UART_LINE_CTRL_ECHO_EN
                        bus.echo_valid <= 1'b1;
                        bus.echo_byte <= bus.data_in;
`endif
                    end else if (isBs && len != '0) begin
                        len <= len - 1'b1;
`ifdef UART_LINE_CTRL_ECHO_EN
                        bus.echo_valid <= 1'b1;
                        bus.echo_byte <= 8'h08;
`endif
                    end else if (isEol && len != '0) begin
                        state <= HOLD;
                        bus.line_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (accept) bus.rx_drop <= 1'b1;
                    if (bus.line_ready) begin
                        bus.line_valid <= 1'b0;
                        len <= '0;
                        state <= COLLECT;
                    end
                end
                default: if (accept && isEol) state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_line_ctrl.sv
// tb_uart_line_ctrl: directed checks of two line controllers (MAX_LEN 32 and 4) fed the same byte stream.
module tb_uart_line_ctrl;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic byteReady = 1'b0;
    logic [7:0] dataIn = '0;
    logic lineReady = 1'b0;
    logic [4:0] rdAddr = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_line_ctrl_if #(.MAX_LEN(32)) b32();
    uart_line_ctrl_if #(.MAX_LEN(4)) b4();
    uart_line_ctrl #(.MAX_LEN(32)) dut32 (.clk(clk), .rst_n(rstN), .bus(b32));
    uart_line_ctrl #(.MAX_LEN(4)) dut4 (.clk(clk), .rst_n(rstN), .bus(b4));

    assign b32.byte_ready = byteReady;
    assign b32.data_in = dataIn;
    assign b32.line_ready = lineReady;
    assign b32.rd_addr = rdAddr;
    assign b4.byte_ready = byteReady;
    assign b4.data_in = dataIn;
    assign b4.line_ready = lineReady;
    assign b4.rd_addr = rdAddr[1:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic st(input string tag, input logic [31:0] v32, input logic [31:0] l32,
                      input logic [31:0] v4, input logic [31:0] l4);
        check({tag, " valid32"}, 32'(b32.line_valid), v32);
        check({tag, " len32"}, 32'(b32.line_len), l32);
        check({tag, " valid4"}, 32'(b4.line_valid), v4);
        check({tag, " len4"}, 32'(b4.line_len), l4);
    endtask

    task automatic pulses(input string tag, input logic [31:0] ov32, input logic [31:0] ov4,
                          input logic [31:0] dr32, input logic [31:0] dr4);
        check({tag, " ovf32"}, 32'(b32.overflow), ov32);
        check({tag, " ovf4"}, 32'(b4.overflow), ov4);
        check({tag, " drop32"}, 32'(b32.rx_drop), dr32);
        check({tag, " drop4"}, 32'(b4.rx_drop), dr4);
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] e32, input logic [31:0] e4);
        rdAddr = a;
        #1;
        check({tag, " rd32"}, 32'(b32.rd_data), e32);
        check({tag, " rd4"}, 32'(b4.rd_data), e4);
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        byteReady = 1'b1;
        dataIn = b;
        @(negedge clk);
        byteReady = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        lineReady = 1'b1;
        @(negedge clk);
        lineReady = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        st("reset", 0, 0, 0, 0);
        pulses("reset", 0, 0, 0, 0);
        rstN = 1'b1;

        sendByte("A"); sendByte("B"); sendByte(8'h0D);
        st("ab_cr", 1, 2, 1, 2);
        rd("ab0", 5'd0, 8'h41, 8'h41);
        rd("ab1", 5'd1, 8'h42, 8'h42);
        ack();
        st("ab_ack", 0, 0, 0, 0);

        sendByte(8'h08);
        st("bs_empty", 0, 0, 0, 0);
        sendByte("A"); sendByte("B");
        st("ab2", 0, 2, 0, 2);
        sendByte(8'h08);
        st("bs", 0, 1, 0, 1);
        sendByte(8'h01);
        st("ctrl_ign", 0, 1, 0, 1);
        sendByte("C"); sendByte(8'h0D);
        st("ac_cr", 1, 2, 1, 2);
        rd("ac0", 5'd0, 8'h41, 8'h41);
        rd("ac1", 5'd1, 8'h43, 8'h43);
        ack();
        sendByte(8'h0A);
        st("lf_blank", 0, 0, 0, 0);
        pulses("lf_blank", 0, 0, 0, 0);

        sendByte("A"); sendByte("B"); sendByte("C"); sendByte("D");
        st("full", 0, 4, 0, 4);
        sendByte("E");
        st("ovf", 0, 5, 0, 0);
        pulses("ovf", 0, 1, 0, 0);
        sendByte("F");
        st("discard", 0, 6, 0, 0);
        pulses("discard", 0, 0, 0, 0);
        sendByte(8'h0D);
        st("ovf_cr", 1, 6, 0, 0);
        rdAddr = 5'd5;
        #1;
        check("long5 rd32", 32'(b32.rd_data), 8'h46);
        ack();
        st("ovf_ack", 0, 0, 0, 0);
        sendByte("X"); sendByte(8'h0D);
        st("x_cr", 1, 1, 1, 1);
        rd("x0", 5'd0, 8'h58, 8'h58);

        sendByte("Z");
        pulses("drop_z", 0, 0, 1, 1);
        st("drop_z", 1, 1, 1, 1);
        rd("drop_z", 5'd0, 8'h58, 8'h58);
        @(negedge clk);
        byteReady = 1'b1;
        dataIn = "Y";
        lineReady = 1'b1;
        @(negedge clk);
        byteReady = 1'b0;
        lineReady = 1'b0;
        pulses("drop_y", 0, 0, 1, 1);
        st("drop_y", 0, 0, 0, 0);
        sendByte("Q");
        pulses("q", 0, 0, 0, 0);
        sendByte(8'h0D);
        st("q_cr", 1, 1, 1, 1);
        rd("q0", 5'd0, 8'h51, 8'h51);
        ack();

        sendByte("A"); sendByte("B");
        st("pre_rst", 0, 2, 0, 2);
        @(negedge clk);
        rstN = 1'b0;
        byteReady = 1'b1;
        dataIn = "C";
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        st("rst_held", 0, 0, 0, 0);
        byteReady = 1'b0;
        sendByte("D");
        st("rst_d", 0, 1, 0, 1);
        rd("rst_d", 5'd0, 8'h44, 8'h44);

`ifdef UART_LINE_CTRL_ECHO_EN
        sendByte(8'h7F);
        check("echo_del v", 32'(b32.echo_valid), 1);
        check("echo_del b", 32'(b32.echo_byte), 8'h08);
        sendByte("A");
        check("echo_a v", 32'(b32.echo_valid), 1);
        check("echo_a b", 32'(b32.echo_byte), 8'h41);
        check("echo_a v4", 32'(b4.echo_valid), 1);
        sendByte(8'h08);
        check("echo_bs v", 32'(b32.echo_valid), 1);
        check("echo_bs b", 32'(b32.echo_byte), 8'h08);
        sendByte(8'h08);
        check("echo_bs2 v", 32'(b32.echo_valid), 0);
        check("echo_bs2 v4", 32'(b4.echo_valid), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_line_ctrl.md
UART_LINE_CTRL -- requirements
Module: uart_line_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, meaning line buffer capacity in bytes (power of two, 4..256).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port byte_ready  input  1  byte strobe from UART receiver.
REQ-005 SHALL have port data_in  input  8  received byte, valid while byte_ready=1.
REQ-006 SHALL have port line_valid  output  1  completed line available.
REQ-007 SHALL have port line_ready  input  1  consumer accepts line.
REQ-008 SHALL have port line_len  output  $clog2(MAX_LEN)+1  byte count of held line.
REQ-009 SHALL have port rd_addr  input  $clog2(MAX_LEN)  buffer read index.
REQ-010 SHALL have port rd_data  output  8  buffer[rd_addr], combinational read.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse when a line exceeds MAX_LEN.
REQ-012 SHALL have port rx_drop  output  1  one-cycle pulse when a received byte is discarded while line_valid=1.

Function
REQ-013 SHALL accept one byte per rising edge of byte_ready (byte_ready=1 this cycle, 0 previous cycle); a held-high strobe is one byte.
REQ-014 SHALL implement states COLLECT, HOLD, DISCARD; register updates from an accepted byte visible on the next clk edge.
REQ-015 COLLECT, byte 0x20..0x7E, len<MAX_LEN: SHALL write buffer[len], len<=len+1.
REQ-016 COLLECT, byte 0x20..0x7E, len==MAX_LEN: SHALL pulse overflow, set len<=0, enter DISCARD.
REQ-017 COLLECT, byte 0x08 or 0x7F: SHALL set len<=len-1 if len>0, else no change (no underflow).
REQ-018 COLLECT, byte 0x0D or 0x0A: SHALL enter HOLD with line_valid=1 if len>0; if len==0 SHALL ignore (CRLF pair yields one line, blank lines dropped).
REQ-019 COLLECT, any other byte: SHALL be ignored silently.
REQ-020 HOLD: line_valid=1, line_len and buffer SHALL stay stable; every accepted byte SHALL be dropped with rx_drop pulse.
REQ-021 HOLD, line_valid=1 and line_ready=1: SHALL clear line_valid, set len<=0, enter COLLECT next cycle; a byte arriving that same cycle is dropped with rx_drop.
REQ-022 DISCARD: SHALL drop all bytes without rx_drop; on 0x0D or 0x0A SHALL return to COLLECT with len=0; overflowed line is never presented.
REQ-023 line_ready while line_valid=0 SHALL have no effect.
REQ-024 line_len SHALL equal len in all states; rd_addr>=line_len returns stale buffer contents (not an error).

Reset
REQ-025 With rst_n=0 at a clk edge: state=COLLECT, len=0, line_valid=0, overflow=0, rx_drop=0, edge-detect history=1 (a byte_ready already high at release is not accepted).
REQ-026 Buffer contents SHALL NOT be reset; reset mid-line or in HOLD discards the line.

Configuration
REQ-027 Macro UART_LINE_CTRL_ECHO_EN defined: SHALL add outputs echo_valid (1) and echo_byte (8), one-cycle pulse one cycle after each byte stored (REQ-015) echoing it, and after each effective backspace (REQ-017, len>0) echoing 0x08; no echo for ignored, dropped or terminator bytes.
REQ-028 Macro undefined: echo ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Bytes "AB",0x0D -> line_valid=1, line_len=2, rd_data[0]=0x41, rd_data[1]=0x42; line_ready=1 -> line_valid=0 next cycle, line_len=0.
REQ-030 "AB",0x08,"C",0x0D,0x0A -> one line, line_len=2, contents 0x41,0x43; 0x0A ignored; 0x08 at len=0 leaves len=0.
REQ-031 MAX_LEN=4: "ABCDE",0x0D,"X",0x0D -> overflow pulse on 'E', no line for "ABCDE", then line "X" with line_len=1.
REQ-032 Line held, send 'Z' with line_ready=0, then 'Y' in same cycle as line_ready=1 -> two rx_drop pulses, line unchanged until handshake, next line starts empty.
REQ-033 rst_n=0 mid-line "AB" with byte_ready held high through release -> len=0, line_valid=0, no byte accepted until byte_ready falls and rises again.
REQ-034 With UART_LINE_CTRL_ECHO_EN: "A",0x08,0x08 -> echo pulses 0x41, 0x08 only (second backspace silent).
